// File: rtl/z80_mem_pkg.sv
// Shared types for the Z80 / video SRAM arbiter: slot FSM encoding and
// the slot counter width.
package z80_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/z80_mreq_detect.sv
// Z80 memory-request front end: catches the falling edge of mreq_n, latches
// the access, and owns cpu_pending / wait_n until the slot retires it.
module z80_mreq_detect #(
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic          cpu_rfsh_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          granted,
    input  logic          done,
    output logic          cpu_pending,
    output logic          cpu_is_wr,
    output logic [AW-1:0] lat_addr,
    output logic [7:0]    lat_dout,
    output logic          cpu_wait_n
);

    logic mreq_l;
    logic start;

    assign start      = !cpu_mreq_n && mreq_l && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n);
    assign cpu_wait_n = !cpu_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreq_l      <= 1'b1;
            cpu_pending <= 1'b0;
            cpu_is_wr   <= 1'b0;
            lat_addr    <= '0;
            lat_dout    <= '0;
        end else begin
            mreq_l <= cpu_mreq_n;
            if (start) begin
                cpu_is_wr <= !cpu_wr_n;
                lat_addr  <= cpu_addr;
                lat_dout  <= cpu_dout;
            end
            // Once a slot owns the access it always runs to completion.
            if (done)
                cpu_pending <= 1'b0;
            else if (start)
                cpu_pending <= 1'b1;
            else if (cpu_mreq_n && !granted)
                cpu_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/z80_sram_arbiter.sv
// Slot scheduler sharing one async SRAM between the Z80 and video fetch;
// video wins ties but never takes two slots in a row over a waiting CPU.
module z80_sram_arbiter
    import z80_mem_pkg::*;
#(
    parameter int AW      = 19,
    parameter int ACC_CYC = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic          cpu_rfsh_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_di,
    output logic          cpu_wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_ack,
    output logic [AW-1:0] sram_a,
    output logic [7:0]    sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [7:0]    sram_dq_i,
    output logic          sram_we_n,
    output logic          sram_oe_n
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_CYC - 1);

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last_vid;
    logic               last, decide, cpu_elig;
    logic               cpu_pending, cpu_is_wr;
    logic [AW-1:0]      lat_addr;
    logic [7:0]         lat_dout;

    z80_mreq_detect #(.AW(AW)) u_mreq (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_mreq_n  (cpu_mreq_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_rfsh_n  (cpu_rfsh_n),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .granted     ((state == ST_CPU) || (nxt == ST_CPU)),
        .done        ((state == ST_CPU) && last),
        .cpu_pending (cpu_pending),
        .cpu_is_wr   (cpu_is_wr),
        .lat_addr    (lat_addr),
        .lat_dout    (lat_dout),
        .cpu_wait_n  (cpu_wait_n)
    );

    always_comb begin
        last     = (state != ST_IDLE) && (cnt == LAST);
        decide   = (state == ST_IDLE) || last;
        // The access being retired this cycle is not a candidate for the next slot.
        cpu_elig = cpu_pending && (state != ST_CPU);
        nxt      = state;
        cnt_nxt  = cnt + 1'b1;
        if (decide) begin
            cnt_nxt = '0;
            if (vid_req && (!cpu_elig || !last_vid))
                nxt = ST_VID;
            else if (cpu_elig)
                nxt = ST_CPU;
            else
                nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_vid   <= 1'b0;
            vid_ack    <= 1'b0;
            vid_data   <= '0;
            cpu_di     <= '0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            vid_ack <= 1'b0;
            if (decide && nxt == ST_VID)
                last_vid <= 1'b1;
            else if (decide && nxt == ST_CPU)
                last_vid <= 1'b0;
            if (state == ST_VID && last) begin
                vid_data <= sram_dq_i;
                vid_ack  <= 1'b1;
            end
            if (state == ST_CPU && last && !cpu_is_wr)
                cpu_di <= sram_dq_i;
            // Pins are set up for the cycle that nxt/cnt_nxt describe.
            case (nxt)
                ST_VID: begin
                    sram_a     <= vid_addr;
                    sram_oe_n  <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
                ST_CPU: begin
                    sram_a     <= lat_addr;
                    sram_dq_o  <= lat_dout;
                    sram_oe_n  <= cpu_is_wr;
                    sram_dq_oe <= cpu_is_wr;
                    // Release WE one cycle early so data and address outlive the strobe.
                    sram_we_n  <= !cpu_is_wr || (cnt_nxt == LAST);
                end
                default: begin
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_sram_arbiter.sv
// Bench for z80_sram_arbiter: directed vector table, multi-cycle corner
// sequences, then concurrent random CPU/video traffic against a memory model.
module tb_z80_sram_arbiter;

    localparam int AW  = 19;
    localparam int ACC = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout, cpu_di;
    logic          cpu_wait_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_ack;
    logic [AW-1:0] sram_a;
    logic [7:0]    sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;

    int checks = 0;
    int errors = 0;

    z80_sram_arbiter #(.AW(AW), .ACC_CYC(ACC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_rfsh_n (cpu_rfsh_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_di     (cpu_di),
        .cpu_wait_n (cpu_wait_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .sram_a     (sram_a),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
    endfunction

    // Async SRAM model: bytes latched on a clock edge while WE is low.
    logic [7:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
        mem[19'h01234] = 8'hA5;
        forever begin
            @(posedge clk);
            if (!sram_we_n && sram_dq_oe) mem[sram_a] = sram_dq_o;
        end
    end
    assign sram_dq_i = sram_oe_n ? 8'hEE : mem[sram_a];

    // Reference contents: pattern unless written by the bench.
    logic [7:0] wr_mem [int];
    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
        return pat(a);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cpu_access(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                              output logic [7:0] di, output int wt, output int oc,
                              output int wc, output int dc, output int ac);
        int n;
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; cpu_mreq_n = 1'b0;
        cpu_rd_n = wr; cpu_wr_n = !wr;
        n = 0; wt = 0; oc = 0; wc = 0; dc = 0; ac = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!cpu_wait_n) wt++;
            if (!sram_oe_n)  oc++;
            if (!sram_we_n)  wc++;
            if (sram_dq_oe)  dc++;
            if (vid_ack)     ac++;
        end while (!cpu_wait_n && n < 60);
        di = cpu_di;
    endtask

    task automatic cpu_release();
        @(negedge clk);
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic vid_drain();
        @(negedge clk);
        vid_req = 1'b0;
        repeat (2*ACC + 3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    exp;
    } vec_t;
    vec_t tv [8];

    logic [7:0] di, last_rd;
    int wt, oc, wc, dc, ac, n, bad;
    bit cpu_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b0, 19'h01234, 8'h00, 8'hA5};
        tv[1] = '{1'b1, 19'h7FFFF, 8'h3C, 8'h00};
        tv[2] = '{1'b0, 19'h7FFFF, 8'h00, 8'h3C};
        tv[3] = '{1'b1, 19'h00000, 8'h00, 8'h00};
        tv[4] = '{1'b0, 19'h00000, 8'h00, 8'h00};
        tv[5] = '{1'b1, 19'h40001, 8'hFF, 8'h00};
        tv[6] = '{1'b0, 19'h40001, 8'h00, 8'hFF};
        tv[7] = '{1'b0, 19'h12345, 8'h00, 8'h3D};
        wr_mem[int'(19'h01234)] = 8'hA5;

        reset_n = 1'b0;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_rfsh_n = 1'b1;
        cpu_addr = '0; cpu_dout = '0; vid_req = 1'b0; vid_addr = '0;
        #23;
        chk("rst_wait_n", cpu_wait_n, 1);
        chk("rst_vid_ack", vid_ack, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_sram_a", int'(sram_a), 0);
        chk("rst_cpu_di", cpu_di, 0);
        chk("rst_vid_data", vid_data, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // CPU-only vector table
        last_rd = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cpu_access(tv[i].wr, tv[i].a, tv[i].d, di, wt, oc, wc, dc, ac);
            cpu_release();
            chk($sformatf("v%0d_wait", i), wt, ACC + 1);
            chk($sformatf("v%0d_oe", i), oc, tv[i].wr ? 0 : ACC);
            chk($sformatf("v%0d_we", i), wc, tv[i].wr ? ACC - 1 : 0);
            chk($sformatf("v%0d_dqoe", i), dc, tv[i].wr ? ACC : 0);
            if (tv[i].wr) begin
                chk($sformatf("v%0d_di_hold", i), di, last_rd);
                chk($sformatf("v%0d_mem", i), mem[tv[i].a], tv[i].d);
                wr_mem[int'(tv[i].a)] = tv[i].d;
            end else begin
                chk($sformatf("v%0d_di", i), di, tv[i].exp);
                last_rd = tv[i].exp;
            end
        end

        // Contention: video streaming, CPU read dropped in
        @(negedge clk); vid_addr = 19'h00100; vid_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!vid_ack && n < 20);
        chk("cont_first_ack", vid_ack, 1);
        cpu_access(1'b0, 19'h40000, 8'h00, di, wt, oc, wc, dc, ac);
        chk_rng("cont_wait", wt, ACC + 1, 2*ACC + 1);
        chk_rng("cont_acks_in_wait", ac, 1, 2);
        chk("cont_di", di, ref_rd(19'h40000));
        ac = 0;
        repeat (4*ACC) begin
            @(posedge clk); #1;
            if (vid_ack) begin
                ac++;
                chk("cont_vid_data", vid_data, ref_rd(19'h00100));
            end
        end
        chk("cont_acks_after", ac, 4);
        cpu_release();
        vid_drain();

        // Refresh cycles must not start a slot
        @(negedge clk); cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (!cpu_wait_n || !sram_oe_n) bad++;
        end
        chk("rfsh_filter", bad, 0);
        @(negedge clk); cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_rfsh_n = 1'b1;
        @(posedge clk);

        // Cancel: write starts alongside a video grant, withdrawn before its slot
        @(negedge clk);
        vid_addr = 19'h00200; vid_req = 1'b1;
        cpu_addr = 19'h45678; cpu_dout = 8'h99; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        @(posedge clk); #1;
        chk("cancel_pending_set", cpu_wait_n, 0);
        @(negedge clk); cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
        bad = 0; n = 0;
        repeat (4*ACC + 4) begin
            @(posedge clk); #1;
            if (!sram_we_n) bad++;
            if (!cpu_wait_n) n++;
        end
        chk("cancel_we_low", bad, 0);
        chk("cancel_wait_low", n, 0);
        chk("cancel_mem", mem[19'h45678], pat(19'h45678));
        vid_drain();

        // Reset asserted during cycle 0 of a write slot
        @(negedge clk);
        cpu_addr = 19'h50000; cpu_dout = 8'h77; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (sram_we_n && n < 10);
        chk("rstw_we_seen", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_we_n", sram_we_n, 1);
        chk("rstw_dq_oe", sram_dq_oe, 0);
        chk("rstw_wait_n", cpu_wait_n, 1);
        @(negedge clk); cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!sram_oe_n || !sram_we_n || sram_dq_oe || !cpu_wait_n) bad++;
        end
        chk("rstw_idle_after", bad, 0);
        chk("rstw_mem", mem[19'h50000], pat(19'h50000));
        cpu_access(1'b0, 19'h7FFFF, 8'h00, di, wt, oc, wc, dc, ac);
        cpu_release();
        chk("rstw_read_di", di, 8'h3C);
        chk("rstw_read_wait", wt, ACC + 1);

        // Random concurrent traffic
        cpu_done = 1'b0;
        fork
            begin
                logic          rw;
                logic [AW-1:0] ra;
                logic [7:0]    rd, rexp, rdi;
                int            rwt, roc, rwc, rdc, rac;
                for (int k = 0; k < 40; k++) begin
                    rw = 1'($urandom_range(0, 1));
                    ra = AW'($urandom);
                    rd = 8'($urandom);
                    if (rw) begin
                        ra[AW-1] = 1'b1;
                        wr_mem[int'(ra)] = rd;
                    end
                    rexp = ref_rd(ra);
                    cpu_access(rw, ra, rd, rdi, rwt, roc, rwc, rdc, rac);
                    cpu_release();
                    chk_rng("rnd_wait", rwt, ACC + 1, 2*ACC + 1);
                    if (!rw) chk("rnd_cpu_di", rdi, rexp);
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                end
                cpu_done = 1'b1;
            end
            begin
                int got, kk, vn;
                while (!cpu_done) begin
                    @(negedge clk);
                    vid_addr = AW'($urandom);
                    vid_addr[AW-1] = 1'b0;
                    vid_req = 1'b1;
                    kk = $urandom_range(1, 3);
                    got = 0; vn = 0;
                    while (got < kk && vn < 200) begin
                        @(posedge clk); #1; vn++;
                        if (vid_ack) begin
                            got++;
                            chk("rnd_vid_data", vid_data, ref_rd(vid_addr));
                        end
                    end
                    chk_rng("rnd_vid_acks", got, kk, kk);
                    @(negedge clk); vid_req = 1'b0;
                    repeat (2*ACC + 3) begin
                        @(posedge clk); #1;
                        if (vid_ack) chk("rnd_vid_drain", vid_data, ref_rd(vid_addr));
                    end
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
